// File: rtl/deser_pkg.sv
// Shared definitions for the serial word deserializer.
// Holds the assembler state enum, the frame-length helper and counter sizing.
// Optional feature macro: DESER_PARITY_EN adds one trailing even-parity bit per frame.
package deser_pkg;

  typedef enum logic [0:0] {
    IDLE,
    ASSEMBLE
  } state_e;

`ifdef DESER_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  // Bits per frame: data bits plus the optional parity bit.
  function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

  localparam int unsigned DefaultDataWidth = 16;
  localparam int unsigned CntWidth = $clog2(frame_len(DefaultDataWidth, ParityEn));

endpackage

// File: rtl/deser_fifo.sv
// Synchronous FIFO for completed words (plus optional parity flag).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   push, push_data   write request and data; caller only pushes when legal
//   pop, pop_data     read request; pop_data shows the head entry
//   full, empty       occupancy flags
//   level             entries currently held
module deser_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [LvlW-1:0]  cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PtrW'(1);
      if (pop)  rd_q <= rd_q + PtrW'(1);
      if (push && !pop)      cnt_q <= cnt_q + LvlW'(1);
      else if (pop && !push) cnt_q <= cnt_q - LvlW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_q];
  assign full     = (cnt_q == LvlW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign level    = cnt_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Rebuilds DATA_WIDTH-bit words from an LSB-first serial stream and delivers
// them through a valid/ready interface backed by a small FIFO.
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   din, din_valid, sof    serial bit, its qualifier, start-of-frame marker
//   dout, dout_valid       FIFO head word (0 when not valid) and its valid
//   dout_ready             consumer accepts the head word
//   overflow               sticky: a completed word found the FIFO full
//   level                  words currently buffered
//   parity_err             head word parity mismatch (DESER_PARITY_EN only)
// Optional feature macro: DESER_PARITY_EN.
module serial_word_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       din,
  input  logic                       din_valid,
  input  logic                       sof,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef DESER_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int unsigned F    = frame_len(DATA_WIDTH, ParityEn);
  localparam int unsigned CntW = $clog2(F);
`ifdef DESER_PARITY_EN
  localparam int unsigned FifoW = DATA_WIDTH + 1;
`else
  localparam int unsigned FifoW = DATA_WIDTH;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [F-1:0]    frame_q, frame_d;
  logic [F-1:0]    frame_cur;
  logic            ovf_q, ovf_d;
  logic            word_done, push, pop;
  logic            fifo_full, fifo_empty;
  logic [FifoW-1:0] push_data, fifo_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    word_done = 1'b0;
    // Frame as it would look with the current bit written at index cnt.
    frame_cur         = frame_q;
    frame_cur[cnt_q]  = din;
    if (din_valid) begin
      if (sof) begin
        // sof realigns in any state, discarding a partial word.
        frame_d    = '0;
        frame_d[0] = din;
        cnt_d      = CntW'(1);
        state_d    = ASSEMBLE;
      end else if (state_q == ASSEMBLE) begin
        if (cnt_q == CntW'(F - 1)) begin
          word_done = 1'b1;
          cnt_d     = '0;
          frame_d   = '0;
        end else begin
          frame_d = frame_cur;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
    end
  end

  assign pop  = !fifo_empty && dout_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push  = word_done && (!fifo_full || pop);
  assign ovf_d = ovf_q | (word_done & fifo_full & !pop);

`ifdef DESER_PARITY_EN
  // Even parity over data plus parity bit: any odd total is a mismatch.
  assign push_data = {^frame_cur, frame_cur[DATA_WIDTH-1:0]};
`else
  assign push_data = frame_cur;
`endif

  deser_fifo #(
    .WIDTH (FifoW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign dout_valid = !fifo_empty;
  assign dout       = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign overflow   = ovf_q;
`ifdef DESER_PARITY_EN
  assign parity_err = !fifo_empty & fifo_dout[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench for serial_word_deserializer: directed scenarios plus
// random traffic, compared every cycle against a queue-based model.
// Optional feature macro: DESER_PARITY_EN.
module tb_serial_word_deserializer;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
`ifdef DESER_PARITY_EN
  localparam int unsigned F = DW + 1;
`else
  localparam int unsigned F = DW;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          din = 1'b0, din_valid = 1'b0, sof = 1'b0, dout_ready = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid, overflow;
  logic [2:0]    level;
  logic          perr;

  serial_word_deserializer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .level      (level)
`ifdef DESER_PARITY_EN
    ,
    .parity_err (perr)
`endif
  );
`ifndef DESER_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: bits of the frame in progress, buffered words.
  bit            aligned = 0;
  bit            cur_bits[$];
  logic [DW-1:0] q_word[$];
  bit            q_err[$];
  bit            m_ovf = 0;
  bit            model_live = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_update(input bit rst, input bit d, input bit v, input bit s,
                              input bit r);
    bit            popped, done;
    logic [DW-1:0] w;
    int            ones;
    if (rst) begin
      aligned = 0; cur_bits.delete(); q_word.delete(); q_err.delete(); m_ovf = 0;
      return;
    end
    popped = (q_word.size() > 0) && r;
    done   = 0;
    w      = '0;
    ones   = 0;
    if (v) begin
      if (s) begin
        cur_bits.delete();
        cur_bits.push_back(d);
        aligned = 1;
      end else if (aligned) begin
        cur_bits.push_back(d);
      end
      if (cur_bits.size() == F) begin
        done = 1;
        for (int k = 0; k < F; k++) begin
          if (cur_bits[k]) begin
            ones++;
            if (k < DW) w = w + (DW'(1) << k);
          end
        end
        cur_bits.delete();
      end
    end
    if (popped) begin
      void'(q_word.pop_front());
      void'(q_err.pop_front());
    end
    if (done) begin
      if (q_word.size() < DEPTH) begin
        q_word.push_back(w);
`ifdef DESER_PARITY_EN
        q_err.push_back(ones % 2 != 0);
`else
        q_err.push_back(1'b0);
`endif
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic cmp_model();
    bit has = q_word.size() > 0;
    chk("dout_valid", 32'(dout_valid), 32'(has));
    chk("dout", 32'(dout), has ? 32'(q_word[0]) : 32'd0);
    chk("level", 32'(level), 32'(q_word.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("parity_err", 32'(perr), has ? 32'(q_err[0]) : 32'd0);
  endtask

  // One clock: drive at negedge, update the model, check #1 after the edge.
  task automatic step(input bit d, input bit v, input bit s, input bit r, input bit rst);
    @(negedge clk);
    din = d; din_valid = v; sof = s; dout_ready = r; reset = rst;
    model_update(rst, d, v, s, r);
    if (rst) model_live = 1;
    @(posedge clk);
    #1;
    if (model_live) cmp_model();
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit with_sof, input bit r,
                           input bit last_r, input bit flip_par);
    logic [DW-1:0] wv;
    bit            b;
    wv = w;
    for (int k = 0; k < F; k++) begin
      b = (k < DW) ? wv[k] : ((^wv) ^ flip_par);
      step(b, 1'b1, with_sof && (k == 0), (k == F - 1) ? last_r : r, 1'b0);
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);

    // Basic word, immediately consumed.
    send_word(16'hA5C3, 1, 1, 1, 0);
    chk("a5c3_valid", 32'(dout_valid), 32'd1);
    chk("a5c3_dout", 32'(dout), 32'hA5C3);
    chk("a5c3_perr", 32'(perr), 32'd0);
    step(0, 0, 0, 1, 0);
    chk("a5c3_popped", 32'(level), 32'd0);

    // Bits without sof after reset are ignored.
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 32; i++) step(1'($urandom), 1, 0, 1, 0);
    chk("nosof_valid", 32'(dout_valid), 32'd0);
    chk("nosof_level", 32'(level), 32'd0);

    // Partial word abandoned by a new sof.
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    send_word(16'h1234, 1, 0, 0, 0);
    chk("realign_level", 32'(level), 32'd1);
    chk("realign_dout", 32'(dout), 32'h1234);
    step(0, 0, 0, 1, 0);
    chk("realign_drained", 32'(level), 32'd0);

    // Overflow: five words into a four-deep FIFO with no consumer.
    for (int i = 1; i <= 5; i++) send_word(DW'(i), i == 1, 0, 0, 0);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(dout), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(dout), 32'(i));
      step(0, 0, 0, 1, 0);
    end
    chk("drain_empty", 32'(dout_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a same-cycle pop accepts the completing word.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) send_word(DW'(16'h10 + i), i == 0, 0, 0, 0);
    send_word(16'h14, 0, 0, 1, 0);
    chk("fullpop_level", 32'(level), 32'd4);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_head", 32'(dout), 32'h11);

    // Reset mid-word, then unaligned bits.
    step(0, 0, 0, 1, 1);
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) step(1, 1, 0, 1, 0);
    chk("midrst_valid", 32'(dout_valid), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
`ifdef DESER_PARITY_EN
    send_word(16'h0003, 1, 0, 0, 1);
    chk("par_dout", 32'(dout), 32'h0003);
    chk("par_err", 32'(perr), 32'd1);
`endif

    // Random traffic.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 999) < 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Serial-in, parallel-out stage that rebuilds DATA_WIDTH-bit words from a one-bit-per-cycle stream, sent LSB first. It is the receive-side counterpart of the parallel-in serial-out shifter: it consumes that block's bit stream and delivers complete words through a valid/ready interface. A small output FIFO absorbs downstream stalls. An explicit start-of-frame strobe realigns word boundaries.

## Interface
- DATA_WIDTH, 16, word width in bits (≥2)
- DEPTH, 4, output FIFO depth in words (power of 2, ≥2)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- din  in  1  serial data bit
- din_valid  in  1  din qualifier; a bit is consumed only when high
- sof  in  1  start-of-frame; meaningful only with din_valid; marks din as bit 0 of a new word
- dout  out  DATA_WIDTH  FIFO head word; 0 whenever dout_valid is low
- dout_valid  out  1  head word available
- dout_ready  in  1  consumer accepts head word when high with dout_valid
- overflow  out  1  sticky; a completed word was dropped
- level  out  $clog2(DEPTH+1)  words currently in FIFO
- parity_err  out  1  present only with DESER_PARITY_EN; parity flag of head word, 0 when dout_valid low

## Operation
- Frame length is F = DATA_WIDTH, or DATA_WIDTH+1 with parity enabled.
- States:
  - IDLE: entered on reset. Every bit without sof is ignored. A valid bit with sof stores bit 0, sets the count to 1 and moves to ASSEMBLE.
  - ASSEMBLE: each valid bit is written to index = count, then count increments.
- Bit k of a frame lands in word bit k (LSB first).
- A frame completes on the valid bit with count = F-1. On completion, count returns to 0 and the state stays ASSEMBLE, so back-to-back words stream with no further sof.
- sof in ASSEMBLE, at any count including F-1:
  - the partial word is discarded with no push;
  - the current bit becomes bit 0 and count becomes 1.
- din_valid low: no state change; gaps of any length between bits are legal.
- FIFO push on completion:
  - accepted if not full, or if full while a pop happens in the same cycle;
  - otherwise the word is dropped and overflow is set.
  - overflow clears only on reset.
- Pop occurs when dout_valid && dout_ready. Words leave in arrival order.
- Push and pop in the same cycle leave level unchanged.

## Timing
- Latency: the word is on dout with dout_valid high in the cycle after the edge that samples its last bit, when the FIFO was empty.
- Throughput: one word per F cycles sustained. The FIFO does not limit this while dout_ready stays high.
- All outputs are registered or decoded from registered state. There is no combinational path from din, din_valid, sof or dout_ready to any output.
- Reset values: dout=0, dout_valid=0, overflow=0, level=0, parity_err=0.
- Reset clears count, the shift register and the FIFO pointers, and returns the state to IDLE.
- Reset mid-word discards the partial word. Afterwards, non-sof bits are ignored until the next sof.
- Reset has priority over all other inputs in the same cycle.

## Configuration
- DESER_PARITY_EN defined:
  - Each frame carries one extra trailing bit, so F = DATA_WIDTH+1.
  - That bit is even parity over the data bits.
  - The computed mismatch is stored alongside the word in the FIFO and presented on parity_err.
  - The word is delivered regardless of the mismatch.
- DESER_PARITY_EN undefined:
  - F = DATA_WIDTH.
  - The parity_err port, its FIFO storage and the parity logic are absent.

## Structure
- Package deser_pkg holds:
  - the state enum {IDLE, ASSEMBLE};
  - the function frame_len(width, parity_en);
  - the localparam for counter width, $clog2(F).
- Sub-module deser_fifo: a synchronous FIFO parameterised by width and DEPTH, with push/pop/full/empty/level ports. It carries word plus optional parity bit.
- The top level contains the state machine, bit counter, shift register and overflow flag.

## Test plan
- Reset, then sof with 16 bits of 0xA5C3 sent LSB first, dout_ready=1 → one cycle after the last bit, dout_valid=1 and dout=0xA5C3; the word pops on the next edge and level returns to 0.
- After reset, 32 valid bits with sof=0 → dout_valid stays 0 and level stays 0.
- sof followed by 5 bits, then sof followed by 16 bits of 0x1234 → exactly one word 0x1234 is delivered.
- dout_ready=0, send 5 back-to-back words 0x0001–0x0005 → level=4 and overflow=1, with 0x0005 dropped. Then set dout_ready=1 → 0x0001–0x0004 are delivered in order; overflow stays 1.
- FIFO full, dout_ready=1 in the same cycle a word completes → push accepted, overflow stays 0, level stays 4.
- Reset asserted after 8 bits of a word, then 16 bits without sof → no output; with DESER_PARITY_EN, a frame 0x0003 followed by parity bit 1 → parity_err=1.
